// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         BYTE_W    = 8;
  localparam int         LEN_W     = 16;
  localparam int         WORD_W    = 32;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              frame_err
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // Line back high at mid start bit: a glitch, not a byte.
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[BYTE_W-1:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (rx_s) valid_d = 1'b1;
          else      err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a UART-delivered image into instruction memory
// and holds the core in reset until a frame with a good checksum completes.
//   state  | meaning
//   SYNC   | after reset, waiting for 0xA5
//   LEN_LO | expecting length low byte
//   LEN_HI | expecting length high byte, range check
//   DATA   | assembling and writing words
//   CHK    | expecting XOR checksum
//   DONE   | image good, core released
//   ERR    | frame aborted, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CYC  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int               TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LD  = TMO_W'(TIMEOUT_CYC);
  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic [BYTE_W-1:0] chk_q, chk_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SYNC;
      len_lo_q     <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHK);

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    word_d       = word_q;
    chk_d        = chk_q;
    tmo_d        = tmo_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    done_d       = done_q;
    err_d        = err_q;

    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (in_frame) begin
      if (byte_valid)          tmo_d = TMO_LD;
      else if (tmo_q != '0)    tmo_d = tmo_q - 1'b1;
    end

    case (state_q)
      ST_SYNC, ST_DONE, ST_ERR: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          chk_d   = '0;
          idx_d   = '0;
          tmo_d   = TMO_LD;
        end
      end
      ST_LEN_LO: begin
        if (byte_valid) begin
          len_lo_d = byte_data;
          chk_d    = chk_q ^ byte_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (byte_valid) begin
          chk_d        = chk_q ^ byte_data;
          words_left_d = {byte_data, len_lo_q};
          idx_d        = '0;
          if ({byte_data, len_lo_q} == '0) begin
            state_d = ST_CHK;
          end else if ({1'b0, byte_data, len_lo_q} > MAX_LEN) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          chk_d = chk_q ^ byte_data;
          idx_d = idx_q + 1'b1;
          case (idx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              we_d         = 1'b1;
              wdata_d      = {byte_data, word_q};
              words_left_d = words_left_q - 1'b1;
              if (words_left_q == LEN_W'(1)) state_d = ST_CHK;
            end
          endcase
        end
      end
      ST_CHK: begin
        if (byte_valid) begin
          if (byte_data == chk_q) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // Framing errors and idle timeout abort any frame in progress.
    if (in_frame && (frame_err || (!byte_valid && tmo_q == '0))) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus hand-written corner sequences.
module tb_imem_loader;

  localparam int CPB    = 8;
  localparam int ADDR_W = 2;
  localparam int TMO    = 200;

  logic              clk;
  logic              rst;
  logic              rx_in;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]       wr_data[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic              bv_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Record every write; each strobe must follow a received byte by one cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_data.push_back(imem_wdata);
      wr_addr.push_back(imem_addr);
      check("we_latency", {31'd0, bv_prev}, 32'd1);
    end
    bv_prev = dut.byte_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_err"},  {31'd0, load_err},  {31'd0, err});
    check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, hold});
  endtask

  task automatic check_writes(input string tag, input int nw, input logic [127:0] words);
    check({tag, "_nwrites"}, wr_data.size(), nw);
    for (int k = 0; k < nw && k < wr_data.size(); k++) begin
      check({tag, "_waddr"}, {30'd0, wr_addr[k]}, k);
      check({tag, "_wdata"}, wr_data[k], words[32*k +: 32]);
    end
  endtask

  typedef struct {
    string        name;
    int           nb;
    logic [191:0] bytes;
    int           nw;
    logic [127:0] words;
    logic         done;
    logic         err;
    logic         hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"good", 12, 192'hA5_02_00_13_00_00_00_93_00_10_00_92, 2,
                128'h00100093_00000013, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"badchk", 12, 192'hA5_02_00_13_00_00_00_93_00_10_00_93, 2,
                128'h00100093_00000013, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"oversize", 3, 192'hA5_05_00, 0, 128'h0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"zerolen", 4, 192'hA5_00_00_00, 0, 128'h0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"maxlen", 20,
                192'hA5_04_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_14, 4,
                128'h100F0E0D_0C0B0A09_08070605_04030201, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"a5data", 9, 192'h33_A5_01_00_A5_A5_A5_A5_01, 1,
                128'hA5A5A5A5, 1'b1, 1'b0, 1'b0};

    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  {30'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Short low glitch must not produce a byte.
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    check("glitch_nwrites", wr_data.size(), 0);
    check_status("glitch", 1'b0, 1'b0, 1'b1);

    for (int v = 0; v < 6; v++) begin
      wr_data.delete();
      wr_addr.delete();
      for (int k = 0; k < vecs[v].nb; k++)
        send_byte(vecs[v].bytes[8*(vecs[v].nb-1-k) +: 8]);
      repeat (3 * CPB) @(negedge clk);
      check_writes(vecs[v].name, vecs[v].nw, vecs[v].words);
      check_status(vecs[v].name, vecs[v].done, vecs[v].err, vecs[v].hold);
    end

    // Idle timeout inside DATA.
    wr_data.delete();
    wr_addr.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    repeat (20) @(negedge clk);
    check_status("tmo_early", 1'b0, 1'b0, 1'b1);
    repeat (250) @(negedge clk);
    check_status("tmo_late", 1'b0, 1'b1, 1'b1);
    check("tmo_nwrites", wr_data.size(), 0);

    // Reset in the middle of a word.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    rst = 1'b0;
    #1;
    check("mrst_we",    {31'd0, imem_we}, 32'd0);
    check("mrst_addr",  {30'd0, imem_addr}, 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check_status("mrst", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("mrst_nwrites", wr_data.size(), 0);

    wr_data.delete();
    wr_addr.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12);
    repeat (3 * CPB) @(negedge clk);
    check_writes("reload", 1, 128'h00000013);
    check_status("reload", 1'b1, 1'b0, 1'b0);

    // Second frame re-raises core_hold while loading.
    wr_data.delete();
    wr_addr.delete();
    send_byte(8'hA5);
    check_status("second_mid", 1'b0, 1'b0, 1'b1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h37);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h36);
    repeat (3 * CPB) @(negedge clk);
    check_writes("second", 1, 128'h00000037);
    check_status("second", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
UART program loader: the writer side of the instruction memory that the fetch stage reads.
- Receives a framed binary image on a serial line and assembles little-endian 32-bit words.
- Writes each word into the instruction-memory write port at sequential word addresses.
- Holds the core pipeline in reset while loading and releases it only after a correct checksum.
- Sits beside the core at top level and shares the board clock.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4
ADDR_W, 10, instruction-memory word-address width (capacity 2^ADDR_W words)
TIMEOUT_CYC, 1_000_000, maximum idle cycles between bytes inside a frame before the frame is aborted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_in  in  1  UART receive line, idle high, asynchronous to clk
imem_we  out  1  one-cycle write strobe to instruction memory
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  write data
core_hold  out  1  1 = keep the core pipeline in reset
load_done  out  1  sticky; last frame loaded with good checksum
load_err  out  1  sticky; last frame aborted (framing, length, checksum, timeout)

Behaviour:
- Reset values (rst=0, asynchronous): imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, load_done=0, load_err=0; FSM=SYNC; receiver idle.
- rx_in passes through a 2-flop synchroniser; it is initialised to 1 at reset.
- UART receive, 8N1, LSB first:
  - A falling edge starts a byte. Re-sample at CLKS_PER_BIT/2; if rx is high, treat it as a glitch and return to idle.
  - Sample each data bit and the stop bit at one-bit intervals from that mid-point.
  - Stop bit = 1: emit byte_valid for one cycle.
  - Stop bit = 0: framing error; the byte is discarded. Inside a frame this forces ERR. In SYNC it is ignored.
- Frame format: 0xA5, LEN_LO, LEN_HI, LEN×4 data bytes (each word little-endian), then CHK.
  - CHK = XOR of LEN_LO, LEN_HI and all data bytes.
- FSM states: SYNC, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
  - SYNC/DONE/ERR: byte 0xA5 → LEN_LO, asserts core_hold=1, clears load_done and load_err, and sets imem_addr=0. Other bytes are ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI, LEN=0 → CHK.
  - LEN_HI, LEN > 2^ADDR_W → ERR.
  - LEN_HI, otherwise → DATA.
  - DATA: byte index 0..3 shifts into the word register at bits [8i+7:8i].
    - On the 4th byte, the cycle after byte_valid: imem_we=1 for exactly one cycle with the current imem_addr and the assembled word.
    - imem_addr increments the cycle after the strobe.
    - After LEN words → CHK.
  - CHK: byte equals the running XOR → DONE (core_hold=0, load_done=1). Mismatch → ERR.
  - ERR: load_err=1, core_hold stays 1.
- Write latency: imem_we asserts exactly 1 cycle after the byte_valid of the word's last byte. Addresses are strictly sequential from 0. There are no writes outside DATA.
- Timeout: in LEN_LO/LEN_HI/DATA/CHK, a counter clears on each byte_valid. When it reaches TIMEOUT_CYC the frame aborts → ERR. The counter does not run in SYNC/DONE/ERR.
- After reset, core_hold stays 1 until the first good frame.
- A new 0xA5 in DONE restarts loading: core_hold=1 again, and memory is overwritten from address 0.
- 0xA5 appearing inside LEN or DATA is data, not a resync.
- A wrapped address is impossible because LEN ≤ 2^ADDR_W. The last valid write is to 2^ADDR_W − 1.
- rst asserted mid-frame: immediate return to reset values. A partial word is never written.

Decomposition:
- Package imem_loader_pkg:
  - FSM state enum
  - SYNC_BYTE = 8'hA5
  - frame field widths
- Sub-module uart_rx_byte:
  - synchroniser, bit timing and framing check
  - outputs byte_valid, byte_data, frame_err
- The top-level module holds the FSM, word assembly, address counter, XOR checksum and timeout.

Test Plan:
- Good frame (CLKS_PER_BIT=8): send A5 02 00 13 00 00 00 93 00 10 00 92 → imem_we pulses twice: addr0=0x00000013, addr1=0x00100093. Then core_hold=0, load_done=1, load_err=0.
- Bad checksum: same frame with last byte 0x93 → both writes occur, core_hold stays 1, load_err=1, load_done=0.
- Oversize length (ADDR_W=2): send A5 05 00 → ERR, load_err=1, zero writes.
- Zero length: send A5 00 00 00 → DONE with no imem_we, core_hold=0.
- Timeout and glitch (TIMEOUT_CYC=200): a 2-cycle low glitch on rx_in in SYNC → no byte, no state change. Then send A5 01 00 13 and go idle for 200+ cycles → ERR, load_err=1, no write.
- Mid-frame reset and reload: reset after A5 01 00 13 00 → all outputs at reset values, no write. Then a full frame A5 01 00 13 00 00 00 12 → single write 0x00000013 at addr 0, load_done=1. A second good frame afterwards re-raises core_hold during the load.
